scr1_imem_cmd_responder: RTL
============================

SCR1_IMEM_CMD_RESPONDER -- requirements
Module: scr1_imem_cmd_responder

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- MEM_WORDS, 1024, backing store depth in 32-bit words (power of 2).
- LATENCY, 2, cycles from request acceptance to response (legal range 1..4).
- CMD_WORD, 32'h1DD19963, instruction word returned on an injection hit.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock for all logic.
- rst_n  in  1  reset; synchronous and active-low.
- imem_req  in  1  core fetch request.
- imem_cmd  in  1  0 = read, 1 = write.
- imem_addr  in  32  byte address.
- imem_req_ack  out  1  request accepted this cycle.
- imem_rdata  out  32  response data.
- imem_resp  out  2  00 IDLE, 01 OKAY, 10 ERROR.
- stall  in  1  wait-state injection; freezes the block.
- cfg_we  in  1  configuration write strobe.
- cfg_sel  in  2  00 memory word, 01 inj_addr, 10 inj_ctrl {oneshot,en}, 11 clear inj_cnt.
- cfg_addr  in  $clog2(MEM_WORDS)  memory word index.
- cfg_wdata  in  32  configuration data.
- inj_cnt  out  16  number of injection hits.

Function
REQ-003 imem_req_ack SHALL be imem_req & ~stall, combinational; each acked cycle is one accepted request.
REQ-004 Each accepted request SHALL enter a LATENCY-stage valid/data pipeline; its response SHALL appear on imem_resp/imem_rdata exactly LATENCY unstalled cycles after acceptance, for one cycle.
REQ-005 Responses SHALL be in acceptance order; back-to-back requests SHALL produce back-to-back responses.
REQ-006 While stall=1: no acceptance, pipeline frozen, imem_resp=IDLE, imem_rdata=0; held responses resume in order when stall drops.
REQ-007 Cycles with no response SHALL drive imem_resp=IDLE and imem_rdata=0.
REQ-008 Classification at acceptance, first match wins:
- imem_cmd=1 -> ERROR, rdata 0.
- imem_addr[1:0]!=0 -> ERROR, rdata 0.
- imem_addr>=MEM_WORDS*4 -> ERROR, rdata 0.
- inj_en=1 and imem_addr==inj_addr -> OKAY, rdata CMD_WORD, injection hit.
- otherwise -> OKAY, rdata mem[imem_addr>>2].
REQ-009 Memory and injection state SHALL be sampled at acceptance; a later cfg write SHALL NOT alter in-flight data.
REQ-010 A cfg write in the same cycle as an acceptance SHALL take effect from the next cycle; the acceptance SHALL use the pre-write value.
REQ-011 Injection hit: inj_cnt increments by 1 on the cycle after acceptance and saturates at 16'hFFFF; if oneshot=1, en clears on the same edge.
REQ-012 cfg_sel=11 with cfg_we SHALL zero inj_cnt; if it coincides with a hit, the clear wins.
REQ-013 cfg_we is honoured regardless of stall.
REQ-014 Memory writes with cfg_sel=00 SHALL write cfg_wdata to mem[cfg_addr].

Reset
REQ-015 When rst_n=0 at a clk edge: pipeline valids cleared (in-flight requests dropped, no response issued), imem_resp=IDLE, imem_rdata=0, inj_en=0, oneshot=0, inj_addr=0, inj_cnt=0.
REQ-016 imem_req_ack SHALL be 0 while rst_n=0.
REQ-017 Memory contents are not reset.
REQ-018 The first request SHALL be accepted in the first cycle with rst_n=1.

Verification
REQ-019 Basic read: cfg mem[4]=32'hDEADBEEF; read 0x10 at cycle T, LATENCY=2 -> OKAY with 32'hDEADBEEF at T+2, IDLE at T+1 and T+3.
REQ-020 Injection one-shot: inj_addr=0x20, ctrl=2'b11, mem[8]=0x13; two reads of 0x20 -> first returns 32'h1DD19963, second returns 0x13; inj_cnt=1 and en=0.
REQ-021 Errors: write to 0x0, read 0x2, and read MEM_WORDS*4 -> three ERROR responses with rdata 0 at acceptance+LATENCY; inj_cnt unchanged.
REQ-022 Stall: requests accepted at T and T+1, stall=1 during T+1..T+3 -> request at T+1 not acked; responses held and released in order after stall drops; no IDLE-gap reorder.
REQ-023 Reset mid-flight: two requests in pipeline, rst_n=0 for one cycle -> no OKAY/ERROR afterwards for them; inj_cnt=0; mem contents preserved.
REQ-024 Counter saturation and clear race: preset via 65535 hits -> inj_cnt holds 16'hFFFF on next hit; hit coinciding with cfg_sel=11 -> inj_cnt=0.

Source files
------------

// File: rtl/scr1_imem_cmd_responder.sv
// Instruction-memory responder: fixed-latency fetch pipeline backed by a word array,
// with a one-address command-injection hook that substitutes CMD_WORD on a hit.
module scr1_imem_cmd_responder #(
    parameter int          MEM_WORDS = 1024,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] CMD_WORD  = 32'h1DD19963
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         imem_req,
    input  logic                         imem_cmd,
    input  logic [31:0]                  imem_addr,
    output logic                         imem_req_ack,
    output logic [31:0]                  imem_rdata,
    output logic [1:0]                   imem_resp,
    input  logic                         stall,
    input  logic                         cfg_we,
    input  logic [1:0]                   cfg_sel,
    input  logic [$clog2(MEM_WORDS)-1:0] cfg_addr,
    input  logic [31:0]                  cfg_wdata,
    output logic [15:0]                  inj_cnt
);

    localparam int          AW        = $clog2(MEM_WORDS);
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [1:0]  RESP_IDLE = 2'b00;
    localparam logic [1:0]  RESP_OKAY = 2'b01;
    localparam logic [1:0]  RESP_ERR  = 2'b10;

    localparam logic [1:0]  SEL_MEM   = 2'b00;
    localparam logic [1:0]  SEL_IADDR = 2'b01;
    localparam logic [1:0]  SEL_ICTRL = 2'b10;
    localparam logic [1:0]  SEL_ICLR  = 2'b11;

    logic [31:0]        mem [MEM_WORDS];
    logic [LATENCY-1:0] pipe_vld;
    logic [1:0]         pipe_resp [LATENCY];
    logic [31:0]        pipe_data [LATENCY];

    logic               inj_en;
    logic               inj_oneshot;
    logic [31:0]        inj_addr;

    logic [1:0]         acc_resp;
    logic [31:0]        acc_data;
    logic               inj_match;
    logic               inj_hit;
    logic               resp_fire;

    // Handshake: a request is accepted in any cycle where imem_req_ack is high;
    // there is no back-pressure on the response side, it is valid for one cycle.
    assign imem_req_ack = imem_req & ~stall & rst_n;
    assign inj_hit      = imem_req_ack & inj_match;

    // Classification sees the registered (pre-write) config and memory contents.
    always_comb begin
        acc_resp  = RESP_OKAY;
        acc_data  = mem[imem_addr[AW+1:2]];
        inj_match = 1'b0;
        if (imem_cmd || (imem_addr[1:0] != 2'b00) || ({1'b0, imem_addr} >= MEM_BYTES)) begin
            acc_resp = RESP_ERR;
            acc_data = '0;
        end else if (inj_en && (imem_addr == inj_addr)) begin
            acc_data  = CMD_WORD;
            inj_match = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_vld <= '0;
        end else if (!stall) begin
            pipe_vld[0] <= imem_req_ack;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!stall) begin
            pipe_resp[0] <= acc_resp;
            pipe_data[0] <= acc_data;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_resp[i] <= pipe_resp[i-1];
                pipe_data[i] <= pipe_data[i-1];
            end
        end
    end

    assign resp_fire  = pipe_vld[LATENCY-1] & ~stall & rst_n;
    assign imem_resp  = resp_fire ? pipe_resp[LATENCY-1] : RESP_IDLE;
    assign imem_rdata = resp_fire ? pipe_data[LATENCY-1] : 32'd0;

    // Later assignments win: an explicit cfg write overrides the hit side effects.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inj_en      <= 1'b0;
            inj_oneshot <= 1'b0;
            inj_addr    <= '0;
            inj_cnt     <= '0;
        end else begin
            if (inj_hit) begin
                if (inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'd1;
                if (inj_oneshot) inj_en <= 1'b0;
            end
            if (cfg_we) begin
                case (cfg_sel)
                    SEL_IADDR: inj_addr <= cfg_wdata;
                    SEL_ICTRL: {inj_oneshot, inj_en} <= cfg_wdata[1:0];
                    SEL_ICLR:  inj_cnt <= '0;
                    default:   ;
                endcase
            end
        end
    end

    // Backing store is deliberately left out of reset so it survives core resets.
    always_ff @(posedge clk) begin
        if (cfg_we && (cfg_sel == SEL_MEM)) begin
            mem[cfg_addr] <= cfg_wdata;
        end
    end

endmodule
